// File: rtl/ram_hs.sv
// Single-port synchronous RAM behind a valid/ready request/response handshake.
// An INIT sweep clears the memory after reset; responses are buffered in order under a credit scheme.
module ram_hs #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 2**ADDR_W,
    parameter int                RD_LAT    = 2,
    parameter int                RSP_DEPTH = 4,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic                rsp_err_o,
    output logic                init_done_o
);

    localparam int                BE_W        = DATA_W / 8;
    localparam int                BUF_D       = RSP_DEPTH - 1;
    localparam int                CNT_W       = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W:0]   DEPTH_L     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L      = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  RSP_DEPTH_L = CNT_W'(RSP_DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   init_cnt_r;
    logic                init_done_r;
    logic                req_ready_r;
    logic [CNT_W-1:0]    credit_r;
    logic [CNT_W-1:0]    credit_nxt_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                req_acc_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic                in_range_s;
    logic [DATA_W-1:0]   rd_data_s;

    logic [RD_LAT-1:0]   pipe_vld_r;
    logic [RD_LAT-1:0]   pipe_err_r;
    logic [DATA_W-1:0]   pipe_data_r [RD_LAT];

    logic                push_s;
    logic                pop_s;
    logic                head_free_s;
    logic [CNT_W-1:0]    wr_idx_s;
    logic [CNT_W-1:0]    buf_cnt_r;
    logic [DATA_W-1:0]   buf_data_r [BUF_D];
    logic [BUF_D-1:0]    buf_err_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_err_r;

    // Credits cover reads in the pipeline plus everything buffered, so the buffer cannot overflow.
    assign req_acc_s    = req_valid_i & req_ready_r;
    assign rd_acc_s     = req_acc_s & ~req_we_i;
    assign wr_acc_s     = req_acc_s & req_we_i;
    assign in_range_s   = ({1'b0, req_addr_i} < DEPTH_L);
    assign rd_data_s    = in_range_s ? mem_r[req_addr_i] : {DATA_W{1'b0}};
    assign pop_s        = rsp_valid_r & rsp_ready_i;
    assign push_s       = pipe_vld_r[RD_LAT-1];
    assign credit_nxt_s = credit_r + CNT_W'(rd_acc_s) - CNT_W'(pop_s);

    assign req_ready_o  = req_ready_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_data_o   = rsp_data_r;
    assign rsp_err_o    = rsp_err_r;
    assign init_done_o  = init_done_r;

    // Next-state logic: INIT sweeps every word once, then RUN until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_L) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Control registers: state, sweep counter, credits and the registered ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= {ADDR_W{1'b0}};
            init_done_r <= 1'b0;
            req_ready_r <= 1'b0;
            credit_r    <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + ADDR_W'(1);
            end
            init_done_r <= (state_nxt_s == ST_RUN);
            credit_r    <= credit_nxt_s;
            req_ready_r <= (state_nxt_s == ST_RUN) && (credit_nxt_s < RSP_DEPTH_L);
        end
    end

    // Storage array: INIT clears one word per cycle, accepted in-range writes merge by byte.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_r == ST_INIT) begin
                mem_r[init_cnt_r] <= INIT_VAL;
            end else if (wr_acc_s && in_range_s) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be_i[b]) begin
                        mem_r[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the array at the accept edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            pipe_err_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0]  <= rd_acc_s;
            pipe_err_r[0]  <= rd_acc_s & ~in_range_s;
            pipe_data_r[0] <= rd_data_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_err_r[i]  <= pipe_err_r[i-1];
                pipe_data_r[i] <= pipe_data_r[i-1];
            end
        end
    end

    // Slot in the backing buffer that an arriving response lands in.
    always_comb begin
        head_free_s = !rsp_valid_r || rsp_ready_i;
        if (head_free_s && (buf_cnt_r != CNT_W'(0))) begin
            wr_idx_s = buf_cnt_r - CNT_W'(1);
        end else begin
            wr_idx_s = buf_cnt_r;
        end
    end

    // Response queue: output register is the head, backed by a shift buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            buf_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (head_free_s) begin
                if (buf_cnt_r != CNT_W'(0)) begin
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= buf_data_r[0];
                    rsp_err_r   <= buf_err_r[0];
                    for (int i = 0; i < BUF_D - 1; i++) begin
                        buf_data_r[i] <= buf_data_r[i+1];
                        buf_err_r[i]  <= buf_err_r[i+1];
                    end
                    if (!push_s) begin
                        buf_cnt_r <= buf_cnt_r - CNT_W'(1);
                    end
                end else if (push_s) begin
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= pipe_data_r[RD_LAT-1];
                    rsp_err_r   <= pipe_err_r[RD_LAT-1];
                end else begin
                    rsp_valid_r <= 1'b0;
                end
            end
            if (push_s && !(head_free_s && (buf_cnt_r == CNT_W'(0)))) begin
                for (int i = 0; i < BUF_D; i++) begin
                    if (CNT_W'(i) == wr_idx_s) begin
                        buf_data_r[i] <= pipe_data_r[RD_LAT-1];
                        buf_err_r[i]  <= pipe_err_r[RD_LAT-1];
                    end
                end
                if (!head_free_s) begin
                    buf_cnt_r <= buf_cnt_r + CNT_W'(1);
                end
            end
        end
    end

endmodule
